// File: rtl/avmm_slave_responder.sv
// Avalon-MM register responder: ID, write/read counters and 13 R/W registers.
// Reads return after READ_LATENCY cycles, fully pipelined; every accepted write stalls the following cycle.
module avmm_slave_responder #(
    parameter int          READ_LATENCY = 2,
    parameter logic [31:0] ID_VALUE     = 32'h5EC7_0003
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] avmm_slave_address,
    input  logic        avmm_slave_read,
    input  logic        avmm_slave_write,
    input  logic [31:0] avmm_slave_writedata,
    input  logic [3:0]  avmm_slave_byteenable,
    output logic        avmm_slave_waitrequest,
    output logic [31:0] avmm_slave_readdata,
    output logic        avmm_slave_readdatavalid
);

    logic        accept_wr;
    logic        accept_rd;
    logic        mapped;
    logic [3:0]  reg_sel;
    logic [31:0] rd_mux;
    logic [31:0] wr_count;
    logic [31:0] rd_count;
    logic [31:0] user_reg [3:15];

    logic [READ_LATENCY-1:0] pipe_vld;
    logic [31:0]             pipe_dat [READ_LATENCY];

    // A simultaneous read+write is a write only.
    assign accept_wr = avmm_slave_write & ~avmm_slave_waitrequest;
    assign accept_rd = avmm_slave_read & ~avmm_slave_write & ~avmm_slave_waitrequest;
    assign mapped    = (avmm_slave_address[19:4] == 16'h0);
    assign reg_sel   = avmm_slave_address[3:0];

    always_comb begin
        rd_mux = 32'hDEAD_BEEF;
        if (mapped) begin
            case (reg_sel)
                4'd0:    rd_mux = ID_VALUE;
                4'd1:    rd_mux = wr_count;
                4'd2:    rd_mux = rd_count;
                default: rd_mux = user_reg[reg_sel];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avmm_slave_waitrequest <= 1'b1;
        end else begin
            avmm_slave_waitrequest <= accept_wr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (accept_wr) begin
                wr_count <= wr_count + 32'd1;
            end
            if (accept_rd) begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 3; i <= 15; i++) begin
                user_reg[i] <= '0;
            end
        end else if (accept_wr && mapped && (reg_sel >= 4'd3)) begin
            for (int b = 0; b < 4; b++) begin
                if (avmm_slave_byteenable[b]) begin
                    user_reg[reg_sel][8*b +: 8] <= avmm_slave_writedata[8*b +: 8];
                end
            end
        end
    end

    // Data stages load only alongside a valid, so the last stage holds between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept_rd;
            if (accept_rd) begin
                pipe_dat[0] <= rd_mux;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                end
            end
        end
    end

    assign avmm_slave_readdatavalid = pipe_vld[READ_LATENCY-1];
    assign avmm_slave_readdata      = pipe_dat[READ_LATENCY-1];

endmodule
